// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - digital clock time/alarm registers, load arbiter and alarm sequencer
//
// Purpose:
//   Holds the current time and alarm time. Arbitrates one-cycle load commands
//   from two requesters (A = UART decoder, B = pushbutton panel). Advances time
//   once per minute from an internal prescaler. Runs the alarm sequencer that
//   arms, rings, snoozes and drives the buzzer.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   a_hour/a_min/a_ld_clk/a_ld_alm requester A time value and load pulses
//   b_hour/b_min/b_ld_clk/b_ld_alm requester B time value and load pulses
//   alarm_en                       level, 0 holds the sequencer in OFF
//   snooze, stop                   one-cycle user pulses
//   ack_a, ack_b                   one-cycle pulse, that requester's request was serviced
//   err                            one-cycle pulse with ack, request out of range and dropped
//   cur_hour/cur_min               current time
//   alm_hour/alm_min               alarm time
//   ringing, snoozing              buzzer enable, snooze indicator
module alarm_scheduler #(
  parameter int TICKS_PER_MIN = 6000000,
  parameter int RING_MIN      = 1,
  parameter int SNOOZE_MIN    = 5,
  parameter int MAX_SNOOZE    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] a_hour,
  input  logic [5:0] a_min,
  input  logic       a_ld_clk,
  input  logic       a_ld_alm,
  input  logic [4:0] b_hour,
  input  logic [5:0] b_min,
  input  logic       b_ld_clk,
  input  logic       b_ld_alm,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err,
  output logic [4:0] cur_hour,
  output logic [5:0] cur_min,
  output logic [4:0] alm_hour,
  output logic [5:0] alm_min,
  output logic       ringing,
  output logic       snoozing
);

  localparam int PW   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int TMAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic       ld_clk;
    logic       ld_alm;
  } req_t;

  typedef enum logic [1:0] {ST_OFF, ST_ARMED, ST_RING, ST_SNOOZE} state_t;

  logic          pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  req_t          slot_a_q, slot_a_d, slot_b_q, slot_b_d;
  logic          rr_q, rr_d;  // 0 = A has priority on contention, 1 = B
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    cur_hour_q, cur_hour_d, alm_hour_q, alm_hour_d;
  logic [5:0]    cur_min_q, cur_min_d, alm_min_q, alm_min_d;
  logic          ack_a_q, ack_b_q, err_q;
  state_t        state_q, state_d;
  logic [TW-1:0] ring_t_q, ring_t_d, snz_t_q, snz_t_d;
  logic [CW-1:0] snz_cnt_q, snz_cnt_d;
  logic          ringing_q, snoozing_q;

  logic grant_a, grant_b, svc, bad;
  logic ld_clk_w, ld_alm_w, tick_raw, tick, match;
  req_t sel;

  // Arbitration works only from registered pend flags, so a pulse is never
  // serviced in the cycle it arrives.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (pend_a_q && pend_b_q) begin
      grant_a = ~rr_q;
      grant_b = rr_q;
    end else begin
      grant_a = pend_a_q;
      grant_b = pend_b_q;
    end
  end

  assign sel      = grant_a ? slot_a_q : slot_b_q;
  assign svc      = grant_a | grant_b;
  assign bad      = (sel.hour > 5'd23) || (sel.min > 6'd59);
  assign ld_clk_w = svc && !bad && sel.ld_clk;
  assign ld_alm_w = svc && !bad && sel.ld_alm;
  assign tick_raw = (presc_q == PW'(TICKS_PER_MIN - 1));
  // A clock load restarts the minute, so a coincident tick is discarded.
  assign tick     = tick_raw && !ld_clk_w;

  always_comb begin
    pend_a_d = pend_a_q;
    slot_a_d = slot_a_q;
    pend_b_d = pend_b_q;
    slot_b_d = slot_b_q;
    if (grant_a) pend_a_d = 1'b0;
    if (grant_b) pend_b_d = 1'b0;
    // A new pulse wins over both the old slot contents and a same-cycle service.
    if (a_ld_clk || a_ld_alm) begin
      pend_a_d = 1'b1;
      slot_a_d = '{hour: a_hour, min: a_min, ld_clk: a_ld_clk, ld_alm: a_ld_alm};
    end
    if (b_ld_clk || b_ld_alm) begin
      pend_b_d = 1'b1;
      slot_b_d = '{hour: b_hour, min: b_min, ld_clk: b_ld_clk, ld_alm: b_ld_alm};
    end
    rr_d = (pend_a_q && pend_b_q) ? ~rr_q : rr_q;
  end

  always_comb begin
    presc_d    = tick_raw ? '0 : presc_q + 1'b1;
    cur_hour_d = cur_hour_q;
    cur_min_d  = cur_min_q;
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    if (ld_clk_w) begin
      presc_d    = '0;
      cur_hour_d = sel.hour;
      cur_min_d  = sel.min;
    end else if (tick) begin
      if (cur_min_q == 6'd59) begin
        cur_min_d  = 6'd0;
        cur_hour_d = (cur_hour_q == 5'd23) ? 5'd0 : cur_hour_q + 5'd1;
      end else begin
        cur_min_d = cur_min_q + 6'd1;
      end
    end
    if (ld_alm_w) begin
      alm_hour_d = sel.hour;
      alm_min_d  = sel.min;
    end
  end

  // Compare against the next-state alarm so a combined clock+alarm load matches.
  assign match = (ld_clk_w || tick) && (cur_hour_d == alm_hour_d) && (cur_min_d == alm_min_d);

  always_comb begin
    state_d   = state_q;
    ring_t_d  = ring_t_q;
    snz_t_d   = snz_t_q;
    snz_cnt_d = snz_cnt_q;
    if (!alarm_en) begin
      state_d   = ST_OFF;
      ring_t_d  = '0;
      snz_t_d   = '0;
      snz_cnt_d = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_d   = ST_RING;
            ring_t_d  = TW'(RING_MIN);
            snz_cnt_d = '0;
          end
        end
        ST_RING: begin
          if (ld_alm_w || stop) begin
            state_d  = ST_ARMED;
            ring_t_d = '0;
            snz_t_d  = '0;
          end else if (snooze && (snz_cnt_q < CW'(MAX_SNOOZE))) begin
            state_d   = ST_SNOOZE;
            snz_t_d   = TW'(SNOOZE_MIN);
            snz_cnt_d = snz_cnt_q + 1'b1;
          end else if (tick) begin
            if (ring_t_q <= TW'(1)) begin
              state_d  = ST_ARMED;
              ring_t_d = '0;
            end else begin
              ring_t_d = ring_t_q - 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (ld_alm_w || stop) begin
            state_d  = ST_ARMED;
            ring_t_d = '0;
            snz_t_d  = '0;
          end else if (tick) begin
            if (snz_t_q <= TW'(1)) begin
              state_d  = ST_RING;
              snz_t_d  = '0;
              ring_t_d = TW'(RING_MIN);
            end else begin
              snz_t_d = snz_t_q - 1'b1;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      rr_q       <= 1'b0;
      presc_q    <= '0;
      cur_hour_q <= '0;
      cur_min_q  <= '0;
      alm_hour_q <= '0;
      alm_min_q  <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= ST_OFF;
      ring_t_q   <= '0;
      snz_t_q    <= '0;
      snz_cnt_q  <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      rr_q       <= rr_d;
      presc_q    <= presc_d;
      cur_hour_q <= cur_hour_d;
      cur_min_q  <= cur_min_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      ack_a_q    <= grant_a;
      ack_b_q    <= grant_b;
      err_q      <= svc && bad;
      state_q    <= state_d;
      ring_t_q   <= ring_t_d;
      snz_t_q    <= snz_t_d;
      snz_cnt_q  <= snz_cnt_d;
      ringing_q  <= (state_d == ST_RING);
      snoozing_q <= (state_d == ST_SNOOZE);
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign err      = err_q;
  assign cur_hour = cur_hour_q;
  assign cur_min  = cur_min_q;
  assign alm_hour = alm_hour_q;
  assign alm_min  = alm_min_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - self-checking bench for alarm_scheduler
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a_hour, b_hour;
  logic [5:0] a_min, b_min;
  logic       a_ld_clk, a_ld_alm, b_ld_clk, b_ld_alm;
  logic       alarm_en, snooze, stop;
  logic       ack_a, ack_b, err, ringing, snoozing;
  logic [4:0] cur_hour, alm_hour;
  logic [5:0] cur_min, alm_min;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit is_b; bit ld_clk; bit ld_alm; int hour; int min;
    bit err; bit chk_cur; int ch; int cm; bit chk_alm; int ah; int am;
  } vec_t;

  typedef struct {
    bit is_b; bit err; int cyc;
    bit chk_cur; int ch; int cm; bit chk_alm; int ah; int am;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[9];

  alarm_scheduler #(.TICKS_PER_MIN(4), .RING_MIN(1), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk(clk), .reset(reset),
    .a_hour(a_hour), .a_min(a_min), .a_ld_clk(a_ld_clk), .a_ld_alm(a_ld_alm),
    .b_hour(b_hour), .b_min(b_min), .b_ld_clk(b_ld_clk), .b_ld_alm(b_ld_alm),
    .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
    .ack_a(ack_a), .ack_b(ack_b), .err(err),
    .cur_hour(cur_hour), .cur_min(cur_min), .alm_hour(alm_hour), .alm_min(alm_min),
    .ringing(ringing), .snoozing(snoozing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && err && !(ack_a || ack_b)) chk("err_without_ack", 1, 0);
    if (!reset && (ack_a || ack_b)) begin
      if (ack_a && ack_b) chk("ack_both", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_requester", int'(ack_b), int'(mon_e.is_b));
        chk("ack_cycle", cyc, mon_e.cyc);
        chk("ack_err", int'(err), int'(mon_e.err));
        if (mon_e.chk_cur) begin
          chk("cur_hour", int'(cur_hour), mon_e.ch);
          chk("cur_min", int'(cur_min), mon_e.cm);
        end
        if (mon_e.chk_alm) begin
          chk("alm_hour", int'(alm_hour), mon_e.ah);
          chk("alm_min", int'(alm_min), mon_e.am);
        end
      end
    end
  end

  task automatic drive_req(input bit is_b, input bit lc, input bit la, input int h, input int m);
    if (is_b) begin
      b_hour = 5'(h); b_min = 6'(m); b_ld_clk = lc; b_ld_alm = la;
    end else begin
      a_hour = 5'(h); a_min = 6'(m); a_ld_clk = lc; a_ld_alm = la;
    end
  endtask

  task automatic clear_req();
    a_ld_clk = 1'b0; a_ld_alm = 1'b0; b_ld_clk = 1'b0; b_ld_alm = 1'b0;
  endtask

  function automatic exp_t mk_exp(input vec_t v, input int c);
    exp_t e;
    e.is_b = v.is_b; e.err = v.err; e.cyc = c;
    e.chk_cur = v.chk_cur; e.ch = v.ch; e.cm = v.cm;
    e.chk_alm = v.chk_alm; e.ah = v.ah; e.am = v.am;
    return e;
  endfunction

  // Drives one request after a posedge, expects its ack two edges later,
  // returns just after that second edge.
  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    drive_req(v.is_b, v.ld_clk, v.ld_alm, v.hour, v.min);
    sb.push_back(mk_exp(v, cyc + 2));
    @(posedge clk); #1;
    clear_req();
    @(posedge clk);
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
  endtask

  task automatic wait_ring(input logic want, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (ringing == want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cur"}, int'({cur_hour, cur_min}), 0);
    chk({name, "_alm"}, int'({alm_hour, alm_min}), 0);
    chk({name, "_flags"}, int'({ack_a, ack_b, err, ringing, snoozing}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d fails %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit ok;
    int t0;

    reset = 1'b1; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    a_hour = '0; a_min = '0; b_hour = '0; b_min = '0;
    clear_req();

    //               is_b ld_c ld_a  hr  mn  err ccur ch  cm  calm ah  am
    tbl[0] = '{1'b0, 1'b1, 1'b0, 10, 15, 1'b0, 1'b1, 10, 15, 1'b0, 0,  0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 24,  0, 1'b1, 1'b1, 10, 15, 1'b0, 0,  0};
    tbl[2] = '{1'b1, 1'b0, 1'b1,  6, 45, 1'b0, 1'b0,  0,  0, 1'b1, 6,  45};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 12, 60, 1'b1, 1'b0,  0,  0, 1'b1, 6,  45};
    tbl[4] = '{1'b0, 1'b1, 1'b1,  5,  5, 1'b0, 1'b1,  5,  5, 1'b1, 5,  5};
    tbl[5] = '{1'b1, 1'b1, 1'b0,  0,  0, 1'b0, 1'b1,  0,  0, 1'b0, 0,  0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 23, 59, 1'b0, 1'b0,  0,  0, 1'b1, 23, 59};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 31, 63, 1'b1, 1'b0,  0,  0, 1'b1, 23, 59};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 23,  0, 1'b0, 1'b1, 23,  0, 1'b0, 0,  0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    // Clock load 23:59, then the first minute tick wraps to 00:00.
    v = '{1'b0, 1'b1, 1'b0, 23, 59, 1'b0, 1'b1, 23, 59, 1'b0, 0, 0};
    apply(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_wrap", int'(cur_hour) * 100 + int'(cur_min), 2359);
    @(posedge clk);
    @(negedge clk);
    chk("wrap", int'(cur_hour) * 100 + int'(cur_min), 0);

    for (int i = 0; i < 9; i++) apply(tbl[i]);

    // Contention with rr at A: A first, B one cycle later.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b1, 7, 30);
    drive_req(1'b1, 1'b1, 1'b0, 7, 29);
    sb.push_back('{1'b0, 1'b0, cyc + 2, 1'b0, 0, 0, 1'b1, 7, 30});
    sb.push_back('{1'b1, 1'b0, cyc + 3, 1'b1, 7, 29, 1'b0, 0, 0});
    @(posedge clk); #1;
    clear_req();
    repeat (4) @(posedge clk);
    // Second contention: pointer moved to B.
    #1;
    drive_req(1'b0, 1'b0, 1'b1, 7, 30);
    drive_req(1'b1, 1'b1, 1'b0, 7, 29);
    sb.push_back('{1'b1, 1'b0, cyc + 2, 1'b1, 7, 29, 1'b0, 0, 0});
    sb.push_back('{1'b0, 1'b0, cyc + 3, 1'b0, 0, 0, 1'b1, 7, 30});
    @(posedge clk); #1;
    clear_req();
    repeat (10) @(posedge clk);

    @(negedge clk);
    alarm_en = 1'b1;
    repeat (2) @(negedge clk);

    // Tick from 07:29 to 07:30 matches the alarm.
    v = '{1'b1, 1'b1, 1'b0, 7, 29, 1'b0, 1'b1, 7, 29, 1'b0, 0, 0};
    apply(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ring_before_match", int'(ringing), 0);
    @(posedge clk);
    @(negedge clk);
    chk("ring_on_match", int'(ringing), 1);
    chk("match_time", int'(cur_hour) * 100 + int'(cur_min), 730);

    for (int i = 0; i < 3; i++) begin
      t0 = cyc;
      pulse_snooze();
      chk("snoozing_set", int'({snoozing, ringing}), 2);
      wait_ring(1'b1, 40, ok);
      chk("snooze_ends", int'(ok), 1);
      chk("snooze_length", cyc - t0, 20);
    end

    t0 = cyc;
    pulse_snooze();
    chk("fourth_snooze_ignored", int'({snoozing, ringing}), 1);
    wait_ring(1'b0, 10, ok);
    chk("ring_timeout", int'(ok), 1);
    chk("ring_length", cyc - t0, 4);

    v = '{1'b1, 1'b1, 1'b0, 7, 29, 1'b0, 1'b1, 7, 29, 1'b0, 0, 0};
    apply(v);
    @(negedge clk);
    wait_ring(1'b1, 10, ok);
    chk("rering", int'(ok), 1);
    snooze = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    stop = 1'b0;
    chk("stop_beats_snooze", int'({snoozing, ringing}), 0);
    @(negedge clk);
    chk("stop_stays_armed", int'({snoozing, ringing}), 0);

    // Reset while ringing with a request pending: no ack ever appears.
    apply(v);
    @(negedge clk);
    wait_ring(1'b1, 10, ok);
    chk("ring_before_reset", int'(ok), 1);
    a_hour = 5'd1; a_min = 6'd0; a_ld_clk = 1'b1;
    @(negedge clk);
    a_ld_clk = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ack_after_reset", int'(ack_a), 0);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
